// File: rtl/fa_vector_checker_if.sv
// fa_vector_checker_if: start pulse, DUT responses, stimulus and run results
interface fa_vector_checker_if;
  logic       start;
  logic       dut_sum;
  logic       dut_cout;
  logic       x;
  logic       y;
  logic       z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_mask;
  logic [3:0] err_count;
  logic [2:0] vec_idx;
  modport master (
    output start, dut_sum, dut_cout,
    input  x, y, z, busy, done, pass, fail_mask, err_count, vec_idx
  );
  modport slave (
    input  start, dut_sum, dut_cout,
    output x, y, z, busy, done, pass, fail_mask, err_count, vec_idx
  );
endinterface

// File: rtl/fa_vector_checker.sv
// fa_vector_checker: exhaustive 8-vector full-adder tester with per-vector fail mask
module fa_vector_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit CHECK_SUM     = 1
) (
  input logic              clk,
  input logic              rst_n,
  fa_vector_checker_if.slave bus
);
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_vec_idx;
  logic [3:0] r_settle;
  logic [7:0] r_fail_mask;
  logic [3:0] r_err_count;
  logic       w_busy;
  logic       w_done;
  logic       w_start;
  logic       w_exp_sum;
  logic       w_exp_cout;
  logic       w_mis;
  assign w_start    = bus.start && !w_busy;
  assign w_exp_sum  = ^r_vec_idx;
  assign w_exp_cout = (r_vec_idx[2] & r_vec_idx[1]) | (r_vec_idx[2] & r_vec_idx[0]) | (r_vec_idx[1] & r_vec_idx[0]);
  // case equality so X/Z responses from the DUT count as mismatches in simulation
  assign w_mis = !(bus.dut_cout === w_exp_cout) || (CHECK_SUM && !(bus.dut_sum === w_exp_sum));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next-state: one vector takes APPLY + SETTLE_CYCLES of WAIT + CHECK
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = bus.start ? APPLY : r_state;
      APPLY:      w_next = WAIT;
      WAIT:       w_next = (r_settle == 4'(SETTLE_CYCLES - 1)) ? CHECK : WAIT;
      CHECK:      w_next = (r_vec_idx == 3'd7) ? DONE : APPLY;
      default:    w_next = IDLE;
    endcase
  end
  // state-decoded status outputs
  always_comb begin
    w_busy = (r_state == APPLY) || (r_state == WAIT) || (r_state == CHECK);
    w_done = (r_state == DONE);
  end
  // vector index and result accumulation; a new start clears the previous run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vec_idx   <= '0;
      r_fail_mask <= '0;
      r_err_count <= '0;
    end else if (w_start) begin
      r_vec_idx   <= '0;
      r_fail_mask <= '0;
      r_err_count <= '0;
    end else if (r_state == CHECK) begin
      if (w_mis) begin
        r_fail_mask[r_vec_idx] <= 1'b1;
        r_err_count            <= r_err_count + 4'd1;
      end
      if (r_vec_idx != 3'd7) r_vec_idx <= r_vec_idx + 3'd1;
    end
  // settle counter runs only in WAIT and is zero on entry from APPLY
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_settle <= '0;
    else        r_settle <= (r_state == WAIT) ? r_settle + 4'd1 : 4'd0;
  assign bus.x         = r_vec_idx[2];
  assign bus.y         = r_vec_idx[1];
  assign bus.z         = r_vec_idx[0];
  assign bus.vec_idx   = r_vec_idx;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pass      = w_done && (r_err_count == 4'd0);
  assign bus.fail_mask = r_fail_mask;
  assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_fa_vector_checker.sv
// tb_fa_vector_checker: random fault-injected full adders against a result model
module tb_fa_vector_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] fs = 8'h00;
  logic [7:0] fc = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  fa_vector_checker_if bus1();
  fa_vector_checker_if bus0();
  fa_vector_checker_if bus3();
  // faulty full adder: fs/fc flip sum/cout for the vector index selecting that bit
  assign bus1.start    = start;
  assign bus1.dut_sum  = (bus1.x ^ bus1.y ^ bus1.z) ^ fs[{bus1.x, bus1.y, bus1.z}];
  assign bus1.dut_cout = ((bus1.x & bus1.y) | (bus1.x & bus1.z) | (bus1.y & bus1.z)) ^ fc[{bus1.x, bus1.y, bus1.z}];
  assign bus0.start    = start;
  assign bus0.dut_sum  = (bus0.x ^ bus0.y ^ bus0.z) ^ fs[{bus0.x, bus0.y, bus0.z}];
  assign bus0.dut_cout = ((bus0.x & bus0.y) | (bus0.x & bus0.z) | (bus0.y & bus0.z)) ^ fc[{bus0.x, bus0.y, bus0.z}];
  assign bus3.start    = start;
  assign bus3.dut_sum  = (bus3.x ^ bus3.y ^ bus3.z) ^ fs[{bus3.x, bus3.y, bus3.z}];
  assign bus3.dut_cout = ((bus3.x & bus3.y) | (bus3.x & bus3.z) | (bus3.y & bus3.z)) ^ fc[{bus3.x, bus3.y, bus3.z}];
  fa_vector_checker #(.SETTLE_CYCLES(1), .CHECK_SUM(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fa_vector_checker #(.SETTLE_CYCLES(1), .CHECK_SUM(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fa_vector_checker #(.SETTLE_CYCLES(3), .CHECK_SUM(1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int exp_idx(input int k, input int per);
    return (k / per > 7) ? 7 : k / per;
  endfunction
  // one full run on all three instances; mid_k > 0 pulses start again at that cycle
  task automatic run(input int mid_k);
    int lat1, lat0, lat3, terr1, terr3;
    logic [7:0] m1, m0;
    lat1 = -1; lat0 = -1; lat3 = -1; terr1 = 0; terr3 = 0;
    m1 = fs | fc;
    m0 = fc;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("clr_done", 32'(bus1.done), 0);
    check("clr_res", 32'({bus1.err_count, bus1.fail_mask}), 0);
    for (int k = 0; k <= 60 && (lat1 < 0 || lat0 < 0 || lat3 < 0); k++) begin
      if (k > 0) begin
        if (k == mid_k) begin @(negedge clk); start = 1'b1; end
        @(posedge clk); #1; start = 1'b0;
      end
      if (lat1 < 0) begin
        if (bus1.done) lat1 = k;
        else if ({bus1.x, bus1.y, bus1.z} != 3'(exp_idx(k, 3)) || !bus1.busy) terr1++;
      end
      if (lat3 < 0) begin
        if (bus3.done) lat3 = k;
        else if ({bus3.x, bus3.y, bus3.z} != 3'(exp_idx(k, 5)) || !bus3.busy) terr3++;
      end
      if (lat0 < 0 && bus0.done) lat0 = k;
    end
    check("lat_s1", 32'(lat1), 24);
    check("lat_cs0", 32'(lat0), 24);
    check("lat_s3", 32'(lat3), 40);
    check("trace_s1", 32'(terr1), 0);
    check("trace_s3", 32'(terr3), 0);
    check("mask_s1", 32'(bus1.fail_mask), 32'(m1));
    check("err_s1", 32'(bus1.err_count), 32'($countones(m1)));
    check("pass_s1", 32'(bus1.pass), 32'(m1 == 8'h00));
    check("busy_s1", 32'(bus1.busy), 0);
    check("mask_cs0", 32'(bus0.fail_mask), 32'(m0));
    check("err_cs0", 32'(bus0.err_count), 32'($countones(m0)));
    check("pass_cs0", 32'(bus0.pass), 32'(m0 == 8'h00));
    check("mask_s3", 32'(bus3.fail_mask), 32'(m1));
    check("err_s3", 32'(bus3.err_count), 32'($countones(m1)));
  endtask
  initial begin
    #12;
    check("rst_out", 32'({bus1.busy, bus1.done, bus1.pass, bus1.x, bus1.y, bus1.z, bus1.fail_mask, bus1.err_count}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'({bus1.busy, bus1.done}), 0);
    fs = 8'h00; fc = 8'h00; run(0);
    fs = 8'h00; fc = 8'hE8; run(0);
    fs = 8'hFF; fc = 8'h00; run(0);
    fs = 8'h00; fc = 8'h00; run(7);
    for (int i = 0; i < 6; i++) begin
      fs = 8'($urandom);
      fc = 8'($urandom);
      run(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0);
    end
    fs = 8'hFF; fc = 8'h00;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 40 && bus1.vec_idx != 3'd4; i++) begin
      @(posedge clk); #1;
    end
    check("reach4", 32'(bus1.vec_idx), 4);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out", 32'({bus1.busy, bus1.done, bus1.pass, bus1.x, bus1.y, bus1.z, bus1.vec_idx, bus1.fail_mask, bus1.err_count}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_autostart", 32'({bus1.busy, bus1.done, bus3.busy}), 0);
    fs = 8'h00; fc = 8'h00; run(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fa_vector_checker.md
FA_VECTOR_CHECKER -- requirements
Module: fa_vector_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1: the number of clock cycles (1..15) between applying a vector and sampling the device under test (DUT).
REQ-002 The block SHALL have parameter CHECK_SUM, default 1: when 1, dut_sum and dut_cout are both compared; when 0, only dut_cout is compared.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins an exhaustive test run.
REQ-006 The block SHALL have ports dut_sum and dut_cout, inputs, 1 bit each: the full-adder responses under test.
REQ-007 The block SHALL have ports x, y and z, outputs, 1 bit each: the stimulus driven to the DUT.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: high from run completion until the next start or reset.
REQ-010 The block SHALL have port pass, output, 1 bit: equal to done AND (err_count == 0).
REQ-011 The block SHALL have port fail_mask, output, 8 bits: bit i set means vector i miscompared.
REQ-012 The block SHALL have port err_count, output, 4 bits: the number of failing vectors (0..8).
REQ-013 The block SHALL have port vec_idx, output, 3 bits: the index of the current vector.

Function
REQ-014 The stimulus SHALL always equal the registered index: x=vec_idx[2], y=vec_idx[1], z=vec_idx[0].
REQ-015 The FSM SHALL have states IDLE, APPLY, WAIT, CHECK, DONE.
REQ-016 In IDLE, start=1 SHALL cause the following on the next edge: vec_idx=0, fail_mask=0, err_count=0, and a move to APPLY.
REQ-017 APPLY SHALL last exactly 1 cycle and then go to WAIT; the WAIT settle counter SHALL be loaded to 0.
REQ-018 WAIT SHALL last exactly SETTLE_CYCLES cycles and then go to CHECK.
REQ-019 CHECK SHALL last 1 cycle and sample the DUT inputs against the expected values: sum = x^y^z and cout = (x&y)|(x&z)|(y&z).
REQ-020 On a mismatch in CHECK, the block SHALL set fail_mask[vec_idx] and increment err_count; with CHECK_SUM=0, dut_sum SHALL be ignored.
REQ-021 CHECK with vec_idx<7 SHALL increment vec_idx and go to APPLY; CHECK with vec_idx==7 SHALL hold vec_idx at 7 and go to DONE (no wrap-around to 0).
REQ-022 Run latency SHALL be exact: done rises 8*(SETTLE_CYCLES+2) cycles after the edge that samples start.
REQ-023 busy SHALL be 1 in APPLY, WAIT and CHECK, and 0 in IDLE and DONE.
REQ-024 start while busy=1 SHALL be ignored, with no effect on state, counters or results.
REQ-025 start in DONE SHALL behave as in IDLE: it clears results, clears done and begins a new run.
REQ-026 fail_mask, err_count and pass SHALL hold stable in DONE.
REQ-027 err_count SHALL equal popcount(fail_mask) at all times.
REQ-028 X/Z values on dut_sum or dut_cout SHALL count as a mismatch.

Reset
REQ-029 rst_n=0 SHALL act immediately, regardless of clk, and set state=IDLE, vec_idx=0, x=y=z=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, and settle counter=0.
REQ-030 Reset during a run SHALL abort it and discard partial results; after rst_n rises, start is required before any new run begins.

Verification
REQ-031 Reference full-adder DUT, SETTLE_CYCLES=1, start pulse -> done=1 exactly 24 cycles later; pass=1, fail_mask=8'h00, err_count=0; x,y,z step through 000..111 in order.
REQ-032 dut_cout stuck at 0 -> fail_mask=8'hE8 (vectors 3,5,6,7), err_count=4, pass=0.
REQ-033 dut_sum inverted -> with CHECK_SUM=1: fail_mask=8'hFF, err_count=8; with CHECK_SUM=0: pass=1, fail_mask=8'h00.
REQ-034 rst_n pulsed low asynchronously while vec_idx=4 -> all outputs are 0 immediately; a subsequent start with a correct DUT gives pass=1 after 24 cycles.
REQ-035 start pulsed at vec_idx=2 mid-run -> no effect, done at cycle 24; a second start in DONE -> done drops the next cycle, results clear, and a new run completes 24 cycles later.
REQ-036 SETTLE_CYCLES=3, reference DUT -> done exactly 40 cycles after start; each vector is held for 5 cycles.
